exec_unit_sequencer: RTL and testbench

- Sequences the execute stage whenever the decoded ALU control code selects a multi-cycle unit: multiply (code 1) or matrix (code 8).
- Issues start/request to the multiply unit or the matrix unit and stalls the pipeline while the op is in flight.
- Selects the write-back result source and pulses write-enable when the result is ready.
- Sits between the ALU control decoder output (ID/EX) and the hazard/stall logic; all single-cycle codes (2,3,4,5,6,7,0) pass through with zero added latency.

---
 rtl/exec_unit_sequencer_pkg.sv | 32 +++
 rtl/exec_unit_sequencer_if.sv | 29 ++
 rtl/exec_unit_sequencer_mc_timeout_counter.sv | 32 +++
 rtl/exec_unit_sequencer.sv | 108 ++++++++++
 tb/tb_exec_unit_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_unit_sequencer_pkg.sv
// Shared constants for the execute-stage multi-cycle sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exec_unit_sequencer_pkg;

  localparam logic [3:0] ALU_MUL = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_EQ  = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_GE  = 4'd7;
  localparam logic [3:0] ALU_MAT = 4'd8;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MUL = 2'd1,
    RES_MAT = 2'd2
  } res_sel_e;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MUL_WAIT  = 3'd1;
  localparam logic [2:0] MAT_REQ   = 3'd2;
  localparam logic [2:0] MAT_WAIT  = 3'd3;
  localparam logic [2:0] MAT_DRAIN = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  function automatic logic is_multi_cycle(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_MAT);
  endfunction

endpackage

// File: rtl/exec_unit_sequencer_if.sv
// EX-stage control, multi-cycle unit handshake and write-back signals.
// Latency: n/a (wiring only).
// Backpressure: stall is the only backpressure toward the pipeline.
interface exec_unit_sequencer_if;
  import exec_unit_sequencer_pkg::*;

  logic       ex_valid;
  logic [3:0] alu_ctrl;
  logic       flush;
  logic       mat_ack;
  logic       mat_done;
  logic       mul_start;
  logic       mat_req;
  logic       stall;
  res_sel_e   res_sel;
  logic       mc_wb_en;
  logic       busy;
  logic       mat_err;

  modport master (
    output ex_valid, alu_ctrl, flush, mat_ack, mat_done,
    input  mul_start, mat_req, stall, res_sel, mc_wb_en, busy, mat_err
  );

  modport slave (
    input  ex_valid, alu_ctrl, flush, mat_ack, mat_done,
    output mul_start, mat_req, stall, res_sel, mc_wb_en, busy, mat_err
  );
endinterface

// File: rtl/exec_unit_sequencer_mc_timeout_counter.sv
// Loadable down-counter that saturates at zero, shared by MUL and MAT paths.
// Latency: load/decrement visible next cycle; flags are combinational.
// Backpressure: none.
module mc_timeout_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  // Set while the count is on its final cycle, so a timeout lands exactly on budget.
  assign last = (cnt <= CNT_W'(1));

endmodule

// File: rtl/exec_unit_sequencer.sv
// Sequences multiply/matrix ops in EX: issues, stalls, selects and writes back.
// Latency: MUL = MUL_LAT+1 cycles to write-back; MAT = until mat_done or MAT_TIMEOUT.
// Backpressure: combinational stall freezes IF/ID/EX; mat_req held until mat_ack.
module exec_unit_sequencer
  import exec_unit_sequencer_pkg::*;
#(
  parameter int MUL_LAT     = 4,
  parameter int MAT_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  exec_unit_sequencer_if.slave  bus
);

  logic [2:0] state, state_nxt;
  res_sel_e   done_sel, done_sel_nxt;
  logic       mat_err_q, err_set;
  logic       mc_code, issue, cnt_zero, expire;
  logic       ack, done;

  assign ack     = bus.mat_ack;
  assign done    = bus.mat_done;
  assign mc_code = bus.ex_valid & ~bus.flush & is_multi_cycle(bus.alu_ctrl);
  assign issue   = (state == IDLE) & mc_code & ~rst;

  mc_timeout_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (issue),
    .load_val ((bus.alu_ctrl == ALU_MUL) ? CNT_W'(MUL_LAT - 1) : CNT_W'(MAT_TIMEOUT - 1)),
    .dec      (state != IDLE),
    .zero     (cnt_zero),
    .last     (expire)
  );

  always_comb begin
    state_nxt    = state;
    done_sel_nxt = done_sel;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (issue) state_nxt = (bus.alu_ctrl == ALU_MUL) ? MUL_WAIT : MAT_REQ;
      end
      MUL_WAIT: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          state_nxt    = DONE;
          done_sel_nxt = RES_MUL;
        end
      end
      MAT_REQ: begin
        // An ack coincident with flush means the unit owns the op; drain it.
        if (bus.flush) begin
          state_nxt = (ack & ~done) ? MAT_DRAIN : IDLE;
        end else if (ack & done) begin
          state_nxt    = DONE;
          done_sel_nxt = RES_MAT;
        end else if (ack) begin
          state_nxt = MAT_WAIT;
        end else if (expire) begin
          state_nxt    = DONE;
          done_sel_nxt = RES_MAT;
          err_set      = 1'b1;
        end
      end
      MAT_WAIT: begin
        if (bus.flush) begin
          state_nxt = (done | expire) ? IDLE : MAT_DRAIN;
        end else if (done) begin
          state_nxt    = DONE;
          done_sel_nxt = RES_MAT;
        end else if (expire) begin
          state_nxt    = DONE;
          done_sel_nxt = RES_MAT;
          err_set      = 1'b1;
        end
      end
      MAT_DRAIN: begin
        if (done | expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done_sel  <= RES_ALU;
      mat_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_sel <= done_sel_nxt;
      if (err_set) mat_err_q <= 1'b1;
    end
  end

  assign bus.mul_start = issue & (bus.alu_ctrl == ALU_MUL);
  assign bus.mat_req   = (issue & (bus.alu_ctrl == ALU_MAT)) | (state == MAT_REQ);
  assign bus.stall     = issue | (state == MUL_WAIT) | (state == MAT_REQ) |
                         (state == MAT_WAIT) | ((state == MAT_DRAIN) & mc_code);
  assign bus.res_sel   = (state == DONE) ? done_sel : RES_ALU;
  assign bus.mc_wb_en  = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.mat_err   = mat_err_q;

endmodule

// File: tb/tb_exec_unit_sequencer.sv
// Bench for exec_unit_sequencer: directed scenarios plus randomized traffic
// compared every cycle against an elapsed-time model of the op lifecycle.
module tb_exec_unit_sequencer;
  localparam int MUL_LAT     = 4;
  localparam int MAT_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  logic cmp_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exec_unit_sequencer_if bus();

  exec_unit_sequencer #(.MUL_LAT(MUL_LAT), .MAT_TIMEOUT(MAT_TIMEOUT), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: op kind (0 none, 1 mul, 2 mat), cycles elapsed since issue, phase flags.
  int         m_kind, m_e;
  logic       m_acked, m_drain, m_wb, m_err;
  logic [1:0] m_sel;
  logic       m_mc, m_idle, m_issue, m_tmo;
  logic       e_mul_start, e_mat_req, e_stall, e_busy, e_wb, e_err;
  logic [1:0] e_sel;

  always_comb begin
    m_mc        = bus.ex_valid & ~bus.flush & ((bus.alu_ctrl == 4'd1) | (bus.alu_ctrl == 4'd8));
    m_idle      = (m_kind == 0) && !m_wb;
    m_issue     = m_idle && m_mc && !rst;
    m_tmo       = (m_e >= MAT_TIMEOUT - 1);
    e_mul_start = m_issue && (bus.alu_ctrl == 4'd1);
    e_mat_req   = (m_issue && (bus.alu_ctrl == 4'd8)) || (m_kind == 2 && !m_acked && !m_drain);
    e_stall     = m_issue || (m_kind != 0 && !m_drain) || (m_kind == 2 && m_drain && m_mc);
    e_busy      = !m_idle;
    e_wb        = m_wb;
    e_sel       = m_wb ? m_sel : 2'd0;
    e_err       = m_err;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_kind <= 0; m_e <= 0; m_acked <= 0; m_drain <= 0; m_wb <= 0; m_err <= 0; m_sel <= 0;
    end else if (m_wb) begin
      m_wb <= 0;
    end else if (m_kind == 0) begin
      if (m_issue) begin
        m_kind <= (bus.alu_ctrl == 4'd1) ? 1 : 2;
        m_e <= 1; m_acked <= 0; m_drain <= 0;
      end
    end else if (m_kind == 1) begin
      if (bus.flush) m_kind <= 0;
      else if (m_e == MUL_LAT) begin m_kind <= 0; m_wb <= 1; m_sel <= 2'd1; end
      else m_e <= m_e + 1;
    end else if (m_drain) begin
      if (bus.mat_done || m_tmo) begin m_kind <= 0; m_drain <= 0; end
      else m_e <= m_e + 1;
    end else if (!m_acked) begin
      if (bus.flush) begin
        if (bus.mat_ack && !bus.mat_done) begin m_drain <= 1; m_e <= m_e + 1; end
        else m_kind <= 0;
      end else if (bus.mat_ack && bus.mat_done) begin
        m_kind <= 0; m_wb <= 1; m_sel <= 2'd2;
      end else if (bus.mat_ack) begin
        m_acked <= 1; m_e <= m_e + 1;
      end else if (m_tmo) begin
        m_kind <= 0; m_wb <= 1; m_sel <= 2'd2; m_err <= 1;
      end else m_e <= m_e + 1;
    end else begin
      if (bus.flush) begin
        if (bus.mat_done || m_tmo) m_kind <= 0;
        else begin m_drain <= 1; m_e <= m_e + 1; end
      end else if (bus.mat_done) begin
        m_kind <= 0; m_wb <= 1; m_sel <= 2'd2;
      end else if (m_tmo) begin
        m_kind <= 0; m_wb <= 1; m_sel <= 2'd2; m_err <= 1;
      end else m_e <= m_e + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_mul_start", 32'(bus.mul_start), 32'(e_mul_start));
      chk("cyc_mat_req",   32'(bus.mat_req),   32'(e_mat_req));
      chk("cyc_stall",     32'(bus.stall),     32'(e_stall));
      chk("cyc_busy",      32'(bus.busy),      32'(e_busy));
      chk("cyc_wb_en",     32'(bus.mc_wb_en),  32'(e_wb));
      chk("cyc_res_sel",   32'(bus.res_sel),   32'(e_sel));
      chk("cyc_mat_err",   32'(bus.mat_err),   32'(e_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.ex_valid = 0; bus.alu_ctrl = 0; bus.flush = 0; bus.mat_ack = 0; bus.mat_done = 0;
  endtask

  task automatic issue_op(input logic [3:0] code);
    bus.ex_valid = 1; bus.alu_ctrl = code;
  endtask

  initial begin
    rst = 1;
    quiet();
    tick();
    cmp_en = 1;
    tick();
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mat_req", 32'(bus.mat_req), 0);
    chk("rst_res_sel", 32'(bus.res_sel), 0);
    chk("rst_mat_err", 32'(bus.mat_err), 0);
    tick();
    rst = 0;

    // Single-cycle code passes straight through.
    for (int i = 0; i < 3; i++) begin
      issue_op(4'd2);
      @(negedge clk);
      chk("alu_stall", 32'(bus.stall), 0);
      chk("alu_res_sel", 32'(bus.res_sel), 0);
      chk("alu_mul_start", 32'(bus.mul_start), 0);
      chk("alu_mat_req", 32'(bus.mat_req), 0);
      tick();
    end
    quiet();
    tick();

    // Multiply: stall c0..c4, write-back at c5.
    issue_op(4'd1);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk("mul_start", 32'(bus.mul_start), 32'(c == 0));
      chk("mul_stall", 32'(bus.stall), 32'(c <= 4));
      chk("mul_wb", 32'(bus.mc_wb_en), 32'(c == 5));
      chk("mul_sel", 32'(bus.res_sel), (c == 5) ? 1 : 0);
      if (c == 5) chk("model_mul_sel", 32'(e_sel), 1);
      tick();
      quiet();
    end

    // Matrix: ack at c2, done at c9, write-back at c10.
    issue_op(4'd8);
    for (int c = 0; c <= 11; c++) begin
      bus.mat_ack = (c == 2);
      bus.mat_done = (c == 9);
      @(negedge clk);
      chk("mat_req", 32'(bus.mat_req), 32'(c <= 2));
      chk("mat_stall", 32'(bus.stall), 32'(c <= 9));
      chk("mat_wb", 32'(bus.mc_wb_en), 32'(c == 10));
      chk("mat_sel", 32'(bus.res_sel), (c == 10) ? 2 : 0);
      chk("mat_err_clean", 32'(bus.mat_err), 0);
      if (c == 10) chk("model_mat_wb", 32'(e_wb), 1);
      tick();
      quiet();
    end

    // Matrix timeout: ack at c1, no done; forced write-back at c64, sticky error.
    issue_op(4'd8);
    for (int c = 0; c <= 66; c++) begin
      bus.mat_ack = (c == 1);
      @(negedge clk);
      chk("tmo_stall", 32'(bus.stall), 32'(c <= 63));
      chk("tmo_wb", 32'(bus.mc_wb_en), 32'(c == 64));
      chk("tmo_err", 32'(bus.mat_err), 32'(c >= 64));
      if (c == 64) chk("model_tmo_err", 32'(e_err), 1);
      tick();
      quiet();
    end
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("tmo_err_cleared", 32'(bus.mat_err), 0);
    tick();

    // Multiply flushed at c2: idle at c3, never written back.
    issue_op(4'd1);
    for (int c = 0; c <= 7; c++) begin
      bus.flush = (c == 2);
      @(negedge clk);
      chk("mflush_busy", 32'(bus.busy), 32'(c >= 1 && c <= 2));
      chk("mflush_stall", 32'(bus.stall), 32'(c <= 2));
      chk("mflush_wb", 32'(bus.mc_wb_en), 0);
      tick();
      quiet();
    end

    // Matrix flushed in wait, a multiply held behind the drain until mat_done.
    for (int c = 0; c <= 12; c++) begin
      bus.ex_valid = (c == 0) || (c >= 3 && c <= 7);
      bus.alu_ctrl = (c == 0) ? 4'd8 : 4'd1;
      bus.mat_ack = (c == 1);
      bus.flush = (c == 3);
      bus.mat_done = (c == 6);
      @(negedge clk);
      chk("drain_mul_start", 32'(bus.mul_start), 32'(c == 7));
      chk("drain_stall", 32'(bus.stall), 32'(c <= 11));
      chk("drain_busy", 32'(bus.busy), 32'(c >= 1 && c != 7));
      chk("drain_wb", 32'(bus.mc_wb_en), 32'(c == 12));
      chk("drain_sel", 32'(bus.res_sel), (c == 12) ? 1 : 0);
      tick();
      quiet();
    end

    // Reset during matrix wait; a later mat_done is ignored.
    issue_op(4'd8);
    for (int c = 0; c <= 7; c++) begin
      bus.mat_ack = (c == 1);
      rst = (c == 3);
      bus.mat_done = (c == 5);
      @(negedge clk);
      if (c >= 4) begin
        chk("rstop_stall", 32'(bus.stall), 0);
        chk("rstop_busy", 32'(bus.busy), 0);
        chk("rstop_mat_req", 32'(bus.mat_req), 0);
        chk("rstop_wb", 32'(bus.mc_wb_en), 0);
      end
      tick();
      quiet();
    end
    rst = 0;

    // Random traffic, busy matrix unit.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.ex_valid = $urandom_range(0, 1);
      bus.alu_ctrl = (r < 3) ? 4'd1 : (r < 6) ? 4'd8 : 4'($urandom_range(0, 15));
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.mat_ack = ($urandom_range(0, 2) == 0);
      bus.mat_done = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    // Random traffic, sluggish matrix unit so timeouts occur.
    for (int n = 0; n < 1500; n++) begin
      bus.ex_valid = $urandom_range(0, 1);
      bus.alu_ctrl = ($urandom_range(0, 1) == 0) ? 4'd8 : 4'($urandom_range(0, 8));
      bus.flush = ($urandom_range(0, 29) == 0);
      bus.mat_ack = ($urandom_range(0, 19) == 0);
      bus.mat_done = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    quiet();
    rst = 0;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
